// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard bus: per-instruction Tuse/Tnew codes in, stall and forwarding selects out.
// The master side is the decode stage, the slave side is the scoreboard.
interface hazard_scoreboard_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned TW     = 3,
  parameter int unsigned STAGES = 3
);
  localparam int unsigned SW = $clog2(STAGES + 1);

  logic              d_valid;
  logic [ADDR_W-1:0] d_rs;
  logic [ADDR_W-1:0] d_rt;
  logic [TW-1:0]     d_tuse_s;
  logic [TW-1:0]     d_tuse_t;
  logic [ADDR_W-1:0] d_dst;
  logic [TW-1:0]     d_tnew;
  logic              d_md_start;
  logic              d_md_use;
  logic              flush;
  logic              stall;
  logic [SW-1:0]     fwd_sel_s;
  logic [SW-1:0]     fwd_sel_t;
  logic              md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_s, d_tuse_t, d_dst, d_tnew, d_md_start, d_md_use, flush,
    input  stall, fwd_sel_s, fwd_sel_t, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_s, d_tuse_t, d_dst, d_tnew, d_md_start, d_md_use, flush,
    output stall, fwd_sel_s, fwd_sel_t, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: shadows destination/Tnew of in-flight instructions and derives
// the decode stall, per-operand forwarding selects and the mult/div interlock.
module hazard_scoreboard #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned TW     = 3,
  parameter int unsigned STAGES = 3,
  parameter int unsigned MD_LAT = 5
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave bus
);
  localparam int unsigned   SW        = $clog2(STAGES + 1);
  localparam int unsigned   CW        = $clog2(MD_LAT + 1);
  localparam logic [TW-1:0] TUSE_NONE = '1;

  logic [ADDR_W-1:0] dst_q  [STAGES];
  logic [ADDR_W-1:0] dst_d  [STAGES];
  logic [TW-1:0]     tnew_q [STAGES];
  logic [TW-1:0]     tnew_d [STAGES];
  logic              e_md_start_q, e_md_start_d;
  logic [CW-1:0]     md_cnt_q, md_cnt_d;

  logic          hit_s, hit_t;
  logic [TW-1:0] tnew_s, tnew_t;
  logic [SW-1:0] idx_s, idx_t;
  logic          data_stall, md_stall;

  // Walk oldest to youngest so the youngest match overwrites any older one.
  always_comb begin
    hit_s  = 1'b0;
    hit_t  = 1'b0;
    tnew_s = '0;
    tnew_t = '0;
    idx_s  = '0;
    idx_t  = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (bus.d_valid && bus.d_rs != '0 && bus.d_tuse_s != TUSE_NONE && dst_q[i] == bus.d_rs) begin
        hit_s  = 1'b1;
        tnew_s = tnew_q[i];
        idx_s  = SW'(i + 1);
      end
      if (bus.d_valid && bus.d_rt != '0 && bus.d_tuse_t != TUSE_NONE && dst_q[i] == bus.d_rt) begin
        hit_t  = 1'b1;
        tnew_t = tnew_q[i];
        idx_t  = SW'(i + 1);
      end
    end
  end

  always_comb begin
    data_stall    = (hit_s && (tnew_s > bus.d_tuse_s)) || (hit_t && (tnew_t > bus.d_tuse_t));
    md_stall      = bus.d_valid && bus.d_md_use && ((md_cnt_q != '0) || e_md_start_q);
    bus.stall     = data_stall || md_stall;
    bus.fwd_sel_s = (hit_s && tnew_s == '0) ? idx_s : '0;
    bus.fwd_sel_t = (hit_t && tnew_t == '0) ? idx_t : '0;
    bus.md_busy   = (md_cnt_q != '0);
  end

  always_comb begin
    dst_d  = dst_q;
    tnew_d = tnew_q;
    // Older stages advance unconditionally; Tnew counts down and saturates at zero.
    for (int i = 1; i < STAGES; i++) begin
      dst_d[i]  = dst_q[i-1];
      tnew_d[i] = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - TW'(1);
    end
    if (bus.stall || bus.flush || !bus.d_valid) begin
      dst_d[0]     = '0;
      tnew_d[0]    = '0;
      e_md_start_d = 1'b0;
    end else begin
      dst_d[0]     = bus.d_dst;
      tnew_d[0]    = bus.d_tnew;
      e_md_start_d = bus.d_md_start;
    end
    if (e_md_start_q) begin
      md_cnt_d = CW'(MD_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - CW'(1);
    end else begin
      md_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        dst_q[i]  <= '0;
        tnew_q[i] <= '0;
      end
      e_md_start_q <= 1'b0;
      md_cnt_q     <= '0;
    end else begin
      dst_q        <= dst_d;
      tnew_q       <= tnew_d;
      e_md_start_q <= e_md_start_d;
      md_cnt_q     <= md_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  hazard_scoreboard_if #(.ADDR_W(5), .TW(3), .STAGES(3)) bus ();

  hazard_scoreboard #(.ADDR_W(5), .TW(3), .STAGES(3), .MD_LAT(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [2:0] tus,
                       input logic [4:0] rt, input logic [2:0] tut, input logic [4:0] dst,
                       input logic [2:0] tnew, input logic mds, input logic mdu, input logic fl);
    bus.d_valid    = v;
    bus.d_rs       = rs;
    bus.d_tuse_s   = tus;
    bus.d_rt       = rt;
    bus.d_tuse_t   = tut;
    bus.d_dst      = dst;
    bus.d_tnew     = tnew;
    bus.d_md_start = mds;
    bus.d_md_use   = mdu;
    bus.flush      = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_drain();
    drive(0, 0, 7, 0, 7, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    drive(0, 0, 7, 0, 7, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b1;
    check("rst_stall", bus.stall, 0);
    check("rst_fwd_s", bus.fwd_sel_s, 0);
    check("rst_fwd_t", bus.fwd_sel_t, 0);
    check("rst_md_busy", bus.md_busy, 0);

    // addu $3 (tnew 1), then subu reads $3 with Tuse 1, then a re-read from M
    drive(1, 1, 7, 2, 7, 3, 1, 0, 0, 0);
    tick();
    drive(1, 3, 1, 4, 1, 6, 1, 0, 0, 0);
    check("alu_stall_e", bus.stall, 0);
    check("alu_fwd_e", bus.fwd_sel_s, 0);
    tick();
    drive(1, 3, 1, 0, 7, 0, 0, 0, 0, 0);
    check("alu_stall_m", bus.stall, 0);
    check("alu_fwd_m", bus.fwd_sel_s, 2);
    tick();
    idle_drain();

    // lw $5 (tnew 2), beq reads $5 twice with Tuse 0
    drive(1, 0, 7, 0, 7, 5, 2, 0, 0, 0);
    tick();
    drive(1, 5, 0, 5, 0, 0, 0, 0, 0, 0);
    check("lw_stall1", bus.stall, 1);
    tick();
    check("lw_stall2", bus.stall, 1);
    tick();
    check("lw_stall3", bus.stall, 0);
    check("lw_fwd_s_w", bus.fwd_sel_s, 3);
    check("lw_fwd_t_w", bus.fwd_sel_t, 3);
    tick();
    idle_drain();

    // $0 writer, then two writers of $7 with tnew 0; youngest wins
    drive(1, 0, 7, 0, 7, 0, 2, 0, 0, 0);
    tick();
    drive(1, 0, 7, 0, 7, 7, 0, 0, 0, 0);
    tick();
    drive(1, 0, 7, 0, 7, 7, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 7, 0, 0, 0, 0, 0, 0);
    check("yng_stall", bus.stall, 0);
    check("yng_fwd_t", bus.fwd_sel_t, 1);
    check("zero_fwd_s", bus.fwd_sel_s, 0);
    drive(1, 0, 0, 7, 7, 0, 0, 0, 0, 0);
    check("tuse_none_fwd_t", bus.fwd_sel_t, 0);
    drive(0, 0, 0, 7, 0, 0, 0, 0, 0, 0);
    check("invalid_fwd_t", bus.fwd_sel_t, 0);
    idle_drain();

    // mult then mfhi: 1 cycle on e_md_start, then MD_LAT cycles of md_busy
    drive(1, 0, 7, 0, 7, 0, 0, 1, 1, 0);
    check("mult_stall", bus.stall, 0);
    tick();
    drive(1, 0, 7, 0, 7, 8, 1, 0, 1, 0);
    check("mfhi_stall_e", bus.stall, 1);
    check("mfhi_busy_e", bus.md_busy, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("mfhi_busy%0d", k), bus.md_busy, 1);
      check($sformatf("mfhi_stall%0d", k), bus.stall, 1);
      tick();
    end
    check("mfhi_release", bus.stall, 0);
    check("mfhi_busy_done", bus.md_busy, 0);
    tick();
    idle_drain();

    // flushed lw $9 leaves only a bubble behind
    drive(1, 0, 7, 0, 7, 9, 2, 0, 0, 1);
    tick();
    drive(1, 9, 0, 9, 0, 0, 0, 0, 0, 0);
    check("flush_stall", bus.stall, 0);
    check("flush_fwd_s", bus.fwd_sel_s, 0);
    tick();
    idle_drain();

    // reset with md_cnt = 3 and a load pending in E
    drive(1, 0, 7, 0, 7, 0, 0, 1, 1, 0);
    tick();
    drive(0, 0, 7, 0, 7, 0, 0, 0, 0, 0);
    tick();
    tick();
    drive(1, 0, 7, 0, 7, 10, 2, 0, 0, 0);
    tick();
    drive(1, 10, 0, 10, 0, 0, 0, 0, 1, 0);
    check("pre_rst_busy", bus.md_busy, 1);
    check("pre_rst_stall", bus.stall, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("post_rst_busy", bus.md_busy, 0);
    check("post_rst_stall", bus.stall, 0);
    check("post_rst_fwd_s", bus.fwd_sel_s, 0);
    check("post_rst_fwd_t", bus.fwd_sel_t, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
